change_dispenser: RTL and testbench

//   Coin-return transmitter for the candy vending machine. Takes a return amount in

---
 rtl/change_dispenser.sv | 89 ++++++++
 tb/tb_change_dispenser.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a return amount one coin at a time, Rs2 first then Re1.
//   clk, rst (async, active-high)
//   load, amount      : start a payout of `amount` rupees when not busy
//   busy              : payout in progress (EJECT/GAP)
//   eject_valid/coin  : coin request to the ejector, coin 0=Re1 1=Rs2
//   eject_ack         : ejector accepts the coin offered
//   done              : one-cycle pulse when the payout is complete
module change_dispenser #(
    parameter int AMT_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             eject_valid,
    output logic             eject_coin,
    input  logic             eject_ack,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, EJECT, GAP, DONE} state_t;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    state_t           state;
    logic [AMT_W-1:0] remaining;
    logic [GW-1:0]    gap_cnt;
    logic [AMT_W-1:0] rem_next;
    // eject_coin doubles as the coin value being paid in EJECT
    assign rem_next = remaining - (eject_coin ? AMT_W'(2) : AMT_W'(1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            gap_cnt     <= '0;
            busy        <= 1'b0;
            eject_valid <= 1'b0;
            eject_coin  <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new load exactly like IDLE
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (load) begin
                        remaining <= amount;
                        if (|amount) begin
                            state       <= EJECT;
                            busy        <= 1'b1;
                            eject_valid <= 1'b1;
                            eject_coin  <= |amount[AMT_W-1:1];
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                EJECT: begin
                    if (eject_ack) begin
                        remaining   <= rem_next;
                        eject_valid <= 1'b0;
                        eject_coin  <= 1'b0;
                        gap_cnt     <= '0;
                        if (~|rem_next) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state       <= EJECT;
                        gap_cnt     <= '0;
                        eject_valid <= 1'b1;
                        eject_coin  <= |remaining[AMT_W-1:1];
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized checks of change_dispenser against a coin-list model.
module tb_change_dispenser;
    localparam int AW  = 4;
    localparam int GAP = 2;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [AW-1:0] amount = '0;
    logic          eject_ack = 1'b0;
    logic          busy, eject_valid, eject_coin, done;
    int            checks = 0;
    int            errors = 0;

    change_dispenser #(.AMT_W(AW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .load(load), .amount(amount), .busy(busy),
        .eject_valid(eject_valid), .eject_coin(eject_coin),
        .eject_ack(eject_ack), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, eject_valid, eject_coin, done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", {busy, eject_valid, eject_coin, done});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, eject_valid, eject_coin, done} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 0000", {busy, eject_valid, eject_coin, done});
        end
    endtask

    // Model: a payout of A is A/2 Rs2 coins followed by A%2 Re1 coin; each coin is offered
    // continuously until acked, with exactly GAP low cycles between coins; done follows the
    // last ack by one cycle (or the load itself when A==0).
    task automatic test_payout(input int a, input int d0, input int dmax, input bit poke, input bit linger);
        bit q[$];
        int wait_n = d0;
        int low_cnt = 0;
        int cyc = 0;
        bit first = 1'b1, hs_last = 1'b0, prev_v = 1'b0, fin = 1'b0, exp_done;
        for (int i = 0; i < a / 2; i++) q.push_back(1'b1);
        if (a % 2 != 0) q.push_back(1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_busy amt=%0d got %b want 0", a, busy);
        end
        load = 1'b1;
        amount = AW'(a);
        tick();
        load = 1'b0;
        while (!fin) begin
            exp_done = (q.size() == 0) && (hs_last || first);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done amt=%0d cyc=%0d got %b want %b", a, cyc, done, exp_done);
            end
            if (exp_done) begin
                checks++;
                if ({busy, eject_valid} !== 2'b00) begin
                    errors++;
                    $display("FAIL done_idle amt=%0d busy,valid got %b want 00", a, {busy, eject_valid});
                end
                fin = 1'b1;
                load = 1'b0;
                eject_ack = 1'b0;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy amt=%0d cyc=%0d got %b want 1", a, cyc, busy);
                end
                if (first || (prev_v && !hs_last)) begin
                    checks++;
                    if (eject_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL valid_hold amt=%0d cyc=%0d got %b want 1", a, cyc, eject_valid);
                    end
                end
                if (eject_valid === 1'b1) begin
                    checks++;
                    if (eject_coin !== q[0]) begin
                        errors++;
                        $display("FAIL coin amt=%0d left=%0d got %b want %b", a, q.size(), eject_coin, q[0]);
                    end
                    if (!first && !prev_v) begin
                        checks++;
                        if (low_cnt != GAP) begin
                            errors++;
                            $display("FAIL gap amt=%0d got %0d want %0d", a, low_cnt, GAP);
                        end
                    end
                    eject_ack = (wait_n == 0);
                    if (wait_n == 0) wait_n = $urandom_range(dmax, 0);
                    else wait_n--;
                end else begin
                    low_cnt++;
                    eject_ack = 1'($urandom_range(1, 0));
                end
                hs_last = (eject_valid === 1'b1) && eject_ack;
                if (hs_last) begin
                    if (q.size() > 0) void'(q.pop_front());
                    low_cnt = 0;
                end
                load = poke && busy && 1'($urandom_range(1, 0));
                if (load) amount = AW'($urandom_range(15, 1));
                prev_v = (eject_valid === 1'b1);
                first = 1'b0;
                tick();
                cyc++;
                if (cyc > 300) begin
                    errors++;
                    $display("FAIL timeout amt=%0d no done after %0d cycles", a, cyc);
                    fin = 1'b1;
                    load = 1'b0;
                    eject_ack = 1'b0;
                end
            end
        end
        if (linger) begin
            tick();
            checks++;
            if ({done, busy, eject_valid} !== 3'b000) begin
                errors++;
                $display("FAIL after_done amt=%0d got %b want 000", a, {done, busy, eject_valid});
            end
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1;
        amount = AW'(6);
        tick();
        load = 1'b0;
        checks++;
        if (eject_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got %b want 1", eject_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, eject_valid, eject_coin, done} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset got %b want 0000", {busy, eject_valid, eject_coin, done});
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({busy, eject_valid, done} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_idle cyc=%0d got %b want 000", i, {busy, eject_valid, done});
            end
        end
        test_payout(1, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        test_payout(3, 0, 0, 1'b0, 1'b0);
        test_payout(2, 1, 0, 1'b0, 1'b0);
        test_payout(0, 0, 0, 1'b0, 1'b0);
        test_payout(1, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            test_payout($urandom_range(15, 0), $urandom_range(5, 0), $urandom_range(3, 0),
                        1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    endtask

    initial begin
        test_reset();
        test_payout(5, 1, 1, 1'b0, 1'b1);
        test_payout(0, 0, 0, 1'b0, 1'b1);
        test_payout(3, 4, 0, 1'b0, 1'b1);
        test_payout(4, 0, 1, 1'b1, 1'b1);
        test_payout(15, 0, 2, 1'b0, 1'b1);
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
